// File: rtl/instruction_decode.sv
// instruction_decode
//   Decode stage of the single-cycle core. Splits the fetched instruction into
//   MIPS-style fields, produces datapath controls and the sign-extended
//   immediate, and holds the general-purpose register file.
// Ports
//   clk, reset             : clock, synchronous active-high reset
//   instruction            : current instruction from fetch
//   wb_en/wb_addr/wb_data  : clocked write-back port
//   rs_data, rt_data       : combinational read ports (with write-back bypass)
//   imm_ext, jump_target   : immediate / jump target fields
//   write_reg, alu_ctrl    : destination index, ALU op
//   reg_write .. jump      : 1-bit datapath controls
//   illegal                : unsupported opcode/funct

// One combinational read port. r0 and reset both read zero; a matching
// write-back in the same cycle is forwarded ahead of the array.
module id_read_port #(
  parameter int DATA_W = 32,
  parameter int NREGS  = 32,
  parameter int AW     = 5
) (
  input  logic [NREGS-1:0][DATA_W-1:0] regs_i,
  input  logic [AW-1:0]                raddr_i,
  input  logic                         reset_i,
  input  logic                         wb_en_i,
  input  logic [AW-1:0]                wb_addr_i,
  input  logic [DATA_W-1:0]            wb_data_i,
  output logic [DATA_W-1:0]            rdata_o
);
  always_comb begin
    rdata_o = regs_i[raddr_i];
    // raddr_i != 0 here, so a match also implies wb_addr_i != 0
    if (reset_i || raddr_i == '0)                  rdata_o = '0;
    else if (wb_en_i && wb_addr_i == raddr_i)      rdata_o = wb_data_i;
  end
endmodule

module instruction_decode #(
  parameter int DATA_W = 32,
  parameter int NREGS  = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [31:0]               instruction,
  input  logic                      wb_en,
  input  logic [$clog2(NREGS)-1:0]  wb_addr,
  input  logic [DATA_W-1:0]         wb_data,
  output logic [DATA_W-1:0]         rs_data,
  output logic [DATA_W-1:0]         rt_data,
  output logic [31:0]               imm_ext,
  output logic [27:0]               jump_target,
  output logic [$clog2(NREGS)-1:0]  write_reg,
  output logic [2:0]                alu_ctrl,
  output logic                      reg_write,
  output logic                      mem_read,
  output logic                      mem_write,
  output logic                      mem_to_reg,
  output logic                      alu_src,
  output logic                      branch,
  output logic                      jump,
  output logic                      illegal
);
  localparam int AW = $clog2(NREGS);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // Field split
  logic [5:0]    opcode, funct;
  logic [AW-1:0] rs, rt, rd;
  assign opcode = instruction[31:26];
  assign rs     = instruction[21 +: AW];
  assign rt     = instruction[16 +: AW];
  assign rd     = instruction[11 +: AW];
  assign funct  = instruction[5:0];

  assign imm_ext     = {{16{instruction[15]}}, instruction[15:0]};
  assign jump_target = {instruction[25:0], 2'b00};

  // Register file
  logic [NREGS-1:0][DATA_W-1:0] regs_q, regs_d;

  always_comb begin
    regs_d = regs_q;
    if (wb_en && wb_addr != '0) regs_d[wb_addr] = wb_data;
  end

  // Reset wins over a concurrent write-back on the same edge
  always_ff @(posedge clk) begin
    if (reset) regs_q <= '0;
    else       regs_q <= regs_d;
  end

  logic [1:0][AW-1:0]     raddr;
  logic [1:0][DATA_W-1:0] rdata;
  assign raddr[0] = rs;
  assign raddr[1] = rt;

  genvar p;
  generate
    for (p = 0; p < 2; p++) begin : g_rport
      id_read_port #(.DATA_W(DATA_W), .NREGS(NREGS), .AW(AW)) u_rport (
        .regs_i    (regs_q),
        .raddr_i   (raddr[p]),
        .reset_i   (reset),
        .wb_en_i   (wb_en),
        .wb_addr_i (wb_addr),
        .wb_data_i (wb_data),
        .rdata_o   (rdata[p])
      );
    end
  endgenerate

  assign rs_data = rdata[0];
  assign rt_data = rdata[1];

  // Control decode
  logic          c_rw, c_mr, c_mw, c_m2r, c_as, c_br, c_j, c_ill;
  logic [2:0]    c_alu;
  logic [AW-1:0] c_wr;

  always_comb begin
    c_rw  = 1'b0; c_mr = 1'b0; c_mw = 1'b0; c_m2r = 1'b0;
    c_as  = 1'b0; c_br = 1'b0; c_j  = 1'b0; c_ill = 1'b0;
    c_alu = ALU_ADD;
    c_wr  = '0;
    unique case (opcode)
      OP_RTYPE: begin
        c_rw = 1'b1;
        c_wr = rd;
        unique case (funct)
          FN_ADD:  c_alu = ALU_ADD;
          FN_SUB:  c_alu = ALU_SUB;
          FN_AND:  c_alu = ALU_AND;
          FN_OR:   c_alu = ALU_OR;
          FN_SLT:  c_alu = ALU_SLT;
          default: begin
            // unsupported funct collapses to the illegal default
            c_rw  = 1'b0;
            c_wr  = '0;
            c_ill = 1'b1;
          end
        endcase
      end
      OP_LW: begin
        c_rw = 1'b1; c_mr = 1'b1; c_m2r = 1'b1; c_as = 1'b1;
        c_wr = rt;
      end
      OP_SW:   begin c_mw = 1'b1; c_as = 1'b1; end
      OP_ADDI: begin c_rw = 1'b1; c_as = 1'b1; c_wr = rt; end
      OP_BEQ:  begin c_br = 1'b1; c_alu = ALU_SUB; end
      OP_J:    c_j = 1'b1;
      default: c_ill = 1'b1;
    endcase
  end

  // Reset masks every control output
  always_comb begin
    reg_write  = c_rw  & ~reset;
    mem_read   = c_mr  & ~reset;
    mem_write  = c_mw  & ~reset;
    mem_to_reg = c_m2r & ~reset;
    alu_src    = c_as  & ~reset;
    branch     = c_br  & ~reset;
    jump       = c_j   & ~reset;
    illegal    = c_ill & ~reset;
    write_reg  = reset ? '0 : c_wr;
    alu_ctrl   = reset ? 3'b000 : c_alu;
  end

endmodule

// File: tb/tb_instruction_decode.sv
module tb_instruction_decode;
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instruction;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic [31:0] rs_data, rt_data, imm_ext;
  logic [27:0] jump_target;
  logic [4:0]  write_reg;
  logic [2:0]  alu_ctrl;
  logic        reg_write, mem_read, mem_write, mem_to_reg, alu_src, branch, jump, illegal;

  always #5 clk = ~clk;

  instruction_decode #(.DATA_W(32), .NREGS(32)) dut (
    .clk(clk), .reset(reset), .instruction(instruction),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .rs_data(rs_data), .rt_data(rt_data), .imm_ext(imm_ext),
    .jump_target(jump_target), .write_reg(write_reg), .alu_ctrl(alu_ctrl),
    .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
    .mem_to_reg(mem_to_reg), .alu_src(alu_src), .branch(branch),
    .jump(jump), .illegal(illegal)
  );

  typedef struct {
    string       tag;
    logic [31:0] rs, rt, imm;
    logic [27:0] jt;
    logic [4:0]  wr;
    logic [2:0]  alu;
    logic [6:0]  ctl;   // {reg_write,mem_read,mem_write,mem_to_reg,alu_src,branch,jump}
    logic        ill;
    bit          chk_alu;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mdl [32];
  int          checks = 0;
  int          failures = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    assert (act === exp) else begin
      failures++;
      $error("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] mread(input logic rst, input logic we,
                                        input logic [4:0] wa, input logic [31:0] wd,
                                        input logic [4:0] ra);
    if (rst || ra == 5'd0)        return 32'h0;
    if (we && wa == ra)           return wd;
    return mdl[ra];
  endfunction

  // Called just after a rising edge: drive, push expectation, check at the
  // falling edge, then advance the register model across the next edge.
  task automatic step(input string tag, input logic [31:0] ins, input logic rst,
                      input logic we, input logic [4:0] wa, input logic [31:0] wd,
                      input logic [6:0] ctl, input logic [2:0] alu,
                      input logic [4:0] wr, input logic ill, input bit chk_alu);
    exp_t e;
    reset = rst; instruction = ins; wb_en = we; wb_addr = wa; wb_data = wd;
    e.tag = tag;
    e.rs  = mread(rst, we, wa, wd, ins[25:21]);
    e.rt  = mread(rst, we, wa, wd, ins[20:16]);
    e.imm = {{16{ins[15]}}, ins[15:0]};
    e.jt  = {ins[25:0], 2'b00};
    e.wr  = rst ? 5'd0 : wr;
    e.ctl = rst ? 7'd0 : ctl;
    e.ill = rst ? 1'b0 : ill;
    e.alu = alu;
    e.chk_alu = chk_alu && !rst;
    sb.push_back(e);
    @(negedge clk);
    e = sb.pop_front();
    chk({e.tag, ".rs"},  rs_data, e.rs);
    chk({e.tag, ".rt"},  rt_data, e.rt);
    chk({e.tag, ".imm"}, imm_ext, e.imm);
    chk({e.tag, ".jt"},  {4'h0, jump_target}, {4'h0, e.jt});
    chk({e.tag, ".wr"},  {27'h0, write_reg}, {27'h0, e.wr});
    chk({e.tag, ".ctl"}, {25'h0, reg_write, mem_read, mem_write, mem_to_reg, alu_src, branch, jump},
                         {25'h0, e.ctl});
    chk({e.tag, ".ill"}, {31'h0, illegal}, {31'h0, e.ill});
    if (e.chk_alu) chk({e.tag, ".alu"}, {29'h0, alu_ctrl}, {29'h0, e.alu});
    @(posedge clk);
    if (rst) foreach (mdl[i]) mdl[i] = 32'h0;
    else if (we && wa != 5'd0) mdl[wa] = wd;
    #1;
  endtask

  initial begin
    foreach (mdl[i]) mdl[i] = 32'h0;
    reset = 1'b1; instruction = 32'h0; wb_en = 1'b0; wb_addr = 5'd0; wb_data = 32'h0;
    @(posedge clk); #1;
    //    tag         instr        rst  we  wa     wdata          ctl         alu     wr     ill  alu?
    step("rst_hold",  32'h012A4022, 1, 0, 5'd0,  32'h0,        7'b1000000, 3'b110, 5'd8,  0, 0);
    step("wr_r5",     32'h00A00020, 0, 1, 5'd5,  32'hDEADBEEF, 7'b1000000, 3'b010, 5'd0,  0, 1);
    step("rd_r5",     32'h00A00020, 0, 0, 5'd0,  32'h0,        7'b1000000, 3'b010, 5'd0,  0, 1);
    step("rst_mid",   32'h00A00020, 1, 1, 5'd5,  32'h11111111, 7'b1000000, 3'b010, 5'd0,  0, 0);
    step("post_rst",  32'h00A00020, 0, 0, 5'd0,  32'h0,        7'b1000000, 3'b010, 5'd0,  0, 1);
    step("sub",       32'h012A4022, 0, 0, 5'd0,  32'h0,        7'b1000000, 3'b110, 5'd8,  0, 1);
    step("lw",        32'h8D28FFFC, 0, 0, 5'd0,  32'h0,        7'b1101100, 3'b010, 5'd8,  0, 1);
    step("sw",        32'hAD280010, 0, 0, 5'd0,  32'h0,        7'b0010100, 3'b010, 5'd0,  0, 1);
    step("addi",      32'h21280005, 0, 0, 5'd0,  32'h0,        7'b1000100, 3'b010, 5'd8,  0, 1);
    step("byp_r9",    32'h01290820, 0, 1, 5'd9,  32'h12345678, 7'b1000000, 3'b010, 5'd1,  0, 1);
    step("arr_r9",    32'h01290820, 0, 0, 5'd0,  32'h0,        7'b1000000, 3'b010, 5'd1,  0, 1);
    step("r0_wr",     32'h00001020, 0, 1, 5'd0,  32'hFFFFFFFF, 7'b1000000, 3'b010, 5'd2,  0, 1);
    step("r0_rd",     32'h00001020, 0, 0, 5'd0,  32'h0,        7'b1000000, 3'b010, 5'd2,  0, 1);
    step("byp_rt",    32'h01251820, 0, 1, 5'd5,  32'hCAFE0005, 7'b1000000, 3'b010, 5'd3,  0, 1);
    step("arr_rt",    32'h01251820, 0, 0, 5'd0,  32'h0,        7'b1000000, 3'b010, 5'd3,  0, 1);
    step("beq",       32'h11090003, 0, 0, 5'd0,  32'h0,        7'b0000010, 3'b110, 5'd0,  0, 1);
    step("j",         32'h08000040, 0, 0, 5'd0,  32'h0,        7'b0000001, 3'b010, 5'd0,  0, 1);
    step("ill_op",    32'hFC000000, 0, 0, 5'd0,  32'h0,        7'b0000000, 3'b010, 5'd0,  1, 1);
    step("ill_fn",    32'h00000001, 0, 0, 5'd0,  32'h0,        7'b0000000, 3'b010, 5'd0,  1, 1);
    step("and",       32'h01095024, 0, 0, 5'd0,  32'h0,        7'b1000000, 3'b000, 5'd10, 0, 1);
    step("or",        32'h01095025, 0, 0, 5'd0,  32'h0,        7'b1000000, 3'b001, 5'd10, 0, 1);
    step("slt",       32'h0109502A, 0, 0, 5'd0,  32'h0,        7'b1000000, 3'b111, 5'd10, 0, 1);
    step("add",       32'h01095020, 0, 0, 5'd0,  32'h0,        7'b1000000, 3'b010, 5'd10, 0, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/instruction_decode.md
# instruction_decode

Decode stage of the single-cycle processor. It sits directly downstream of `instruction_fetch` and consumes its 32-bit `instruction`. It splits the instruction into MIPS-style fields, generates the datapath control signals and sign-extended immediate, and holds the 32×32 general-purpose register file. The file has two combinational read ports and one clocked write-back port.

## Interface

Parameters:
- `DATA_W`, 32: register and data width.
- `NREGS`, 32: register count. The address width is log2(NREGS) = 5.

Ports:
- `clk`  input  1  rising-edge clock. Same clock as `instruction_fetch`.
- `reset`  input  1  synchronous, active-high. Sampled on the rising edge of `clk`.
- `instruction`  input  32  current instruction from `instruction_fetch`.
- `wb_en`  input  1  write-back enable.
- `wb_addr`  input  5  write-back register index.
- `wb_data`  input  32  write-back value.
- `rs_data`  output  32  value of register `instruction[25:21]`.
- `rt_data`  output  32  value of register `instruction[20:16]`.
- `imm_ext`  output  32  sign-extended `instruction[15:0]`.
- `jump_target`  output  28  `{instruction[25:0], 2'b00}`.
- `write_reg`  output  5  destination register index.
- `alu_ctrl`  output  3  ALU operation code.
- `reg_write`, `mem_read`, `mem_write`, `mem_to_reg`, `alu_src`, `branch`, `jump`  output  1 each  control signals.
- `illegal`  output  1  the opcode/funct pair is unsupported.

## Operation

- Field split:
  - opcode = [31:26], rs = [25:21], rt = [20:16], rd = [15:11], funct = [5:0].
- `alu_ctrl` encoding: and = 000, or = 001, add = 010, sub = 110, slt = 111.
- Decoded instructions (control signals not listed are 0):
  - opcode 0x00, R-type, funct 0x20/0x22/0x24/0x25/0x2A maps to add/sub/and/or/slt. `reg_write` = 1, `write_reg` = rd.
  - 0x23 lw: `reg_write`, `mem_read`, `mem_to_reg`, `alu_src` = 1. `alu_ctrl` = add. `write_reg` = rt.
  - 0x2B sw: `mem_write`, `alu_src` = 1. `alu_ctrl` = add.
  - 0x08 addi: `reg_write`, `alu_src` = 1. `alu_ctrl` = add. `write_reg` = rt.
  - 0x04 beq: `branch` = 1. `alu_ctrl` = sub.
  - 0x02 j: `jump` = 1.
- Default values: `write_reg` = 0 and `alu_ctrl` = 010 whenever not listed above.
- Any other opcode, or R-type with any other funct:
  - all control signals 0, `write_reg` = 0, `alu_ctrl` = 010, `illegal` = 1.
  - `rs_data`, `rt_data` and `imm_ext` are still driven normally.
- Register file:
  - 32 registers.
  - Register 0 always reads 0. Writes to index 0 are discarded.
  - Write: on a rising edge with `wb_en` = 1, `reset` = 0 and `wb_addr` ≠ 0, `reg[wb_addr]` ← `wb_data`.
  - Read: combinational.
  - Same-cycle bypass: if `wb_en` = 1, `wb_addr` ≠ 0 and `wb_addr` equals a read index, that port returns `wb_data`. rs and rt are bypassed independently; both bypass when they match.
- Reset:
  - a rising edge with `reset` = 1 clears all 32 registers to 0.
  - A concurrent `wb_en` is ignored.
  - While `reset` = 1, all control outputs, `write_reg` and `illegal` are forced to 0, and `rs_data`/`rt_data` read 0 (bypass disabled).
  - Reset asserted mid-program takes effect at the next edge; no write completes on that edge.

## Timing

- Decode, immediate, jump target and register reads are purely combinational from `instruction`, and from `wb_*` via the bypass. Latency is 0 cycles.
- Register writes commit at the rising edge and are visible through the array one cycle later, or immediately through the bypass.
- Reset values, which hold from the first edge with `reset` = 1: every register = 0, all 1-bit outputs = 0, `write_reg` = 0, `rs_data` = `rt_data` = 0.
- No handshake. One instruction is decoded per cycle, matching the one-instruction-per-cycle output of `instruction_fetch`.

## Test plan

- **Reset clears the file.**
  - Write 0xDEADBEEF to r5.
  - Assert `reset` for 1 edge.
  - Deassert, apply 0x00A00020 (add r0, r5, r0).
  - Required: `rs_data` = 0.
- **R-type decode.**
  - Apply 0x012A4022 (sub r8, r9, r10).
  - Required: `alu_ctrl` = 110, `reg_write` = 1, `write_reg` = 8, `alu_src` = 0, `illegal` = 0.
- **I-type and immediate.**
  - Apply 0x8D28FFFC (lw r8, -4(r9)).
  - Required: `imm_ext` = 0xFFFFFFFC, `mem_read` = `mem_to_reg` = `alu_src` = `reg_write` = 1, `write_reg` = 8.
  - Apply 0xAD280010 (sw).
  - Required: `mem_write` = 1, `reg_write` = 0.
- **Write-back and bypass.**
  - Same cycle: `wb_en` = 1, `wb_addr` = 9, `wb_data` = 0x12345678, instruction rs = 9, rt = 9.
  - Required: both ports = 0x12345678 in that cycle and on the next cycle with `wb_en` = 0.
- **r0 protection.**
  - `wb_en` = 1, `wb_addr` = 0, `wb_data` = 0xFFFFFFFF.
  - Required: reading r0 returns 0 both in that cycle and after the edge.
- **Branch, jump and illegal.**
  - 0x11090003 (beq): `branch` = 1, `alu_ctrl` = 110.
  - 0x08000040 (j): `jump` = 1, `jump_target` = 0x0000100.
  - 0xFC000000: `illegal` = 1, all control = 0.
  - 0x00000001 (R-type, funct 1): `illegal` = 1.
